// File: rtl/addsub_serial.sv
// Digit-serial add/subtract/accumulate unit with start/busy/done handshake.
// Processes DIGIT bits per clock; result and C/O/Z flags update once per operation.
module addsub_serial #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           Command,
    input  logic [WIDTH-1:0]     inputP,
    input  logic [WIDTH-1:0]     inputQ,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] S,
    output logic                 C,
    output logic                 O,
    output logic                 Z
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       res_q, res_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic                   cmsb_q, cmsb_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [OUT_WIDTH-1:0]   s_q, s_d;
    logic                   c_q, c_d;
    logic                   o_q, o_d;
    logic                   z_q, z_d;

    logic [DIGIT-1:0]       sum_s;
    logic [DIGIT:0]         chain_s;
    logic [WIDTH-1:0]       res_shift_s;
    logic                   cmd_valid_s;
    logic                   mode_s;
    logic                   acc_cmd_s;

    assign cmd_valid_s = (Command >= 4'd2) && (Command <= 4'd5);
    assign mode_s      = (Command == 4'd3) || (Command == 4'd5);
    assign acc_cmd_s   = (Command == 4'd4) || (Command == 4'd5);

    // Ripple of DIGIT full-adder cells over the low digit of A and B.
    always_comb begin
        chain_s    = '0;
        sum_s      = '0;
        chain_s[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            sum_s[i]       = a_q[i] ^ b_q[i] ^ chain_s[i];
            chain_s[i + 1] = (a_q[i] & b_q[i]) | (chain_s[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New sum digit enters the result register from the top.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_shift_s = sum_s;
        end else begin : g_multi
            assign res_shift_s = {sum_s, res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state and datapath update for IDLE/RUN/DONE sequencing.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        c_d     = c_q;
        o_d     = o_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start && cmd_valid_s) begin
                    a_d     = acc_cmd_s ? acc_q : inputP;
                    b_d     = (acc_cmd_s ? inputP : inputQ) ^ {WIDTH{mode_s}};
                    carry_d = mode_s;
                    mode_d  = mode_s;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift_s;
                carry_d = chain_s[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cmsb_d  = chain_s[DIGIT-1];
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                s_d     = OUT_WIDTH'(res_q);
                // Carry-out is inverted for subtraction so C reads as borrow.
                c_d     = carry_q ^ mode_q;
                o_d     = cmsb_q ^ carry_q;
                z_d     = (res_q == {WIDTH{1'b0}});
                acc_d   = res_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= {OUT_WIDTH{1'b0}};
            c_q     <= 1'b0;
            o_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            c_q     <= c_d;
            o_q     <= o_d;
            z_q     <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign C    = c_q;
    assign O    = o_q;
    assign Z    = z_q;

endmodule
